sram_bank_model: RTL and testbench



---
 rtl/sram_bank_model_pkg.sv | 20 ++
 rtl/sram_edge_sync.sv | 23 ++
 rtl/sram_bank_model.sv | 197 +++++++++++++++++++
 tb/tb_sram_bank_model.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bank_model_pkg.sv
// Shared constants and state encoding for the external SRAM bank model and its benches.
package sram_bank_model_pkg;

    localparam int CLK_PERIOD_BRD_PS = 50000;
    localparam int MODE_PATTERN      = 0;
    localparam int MODE_RAM          = 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_WAIT  = 2'd1,
        RD_DRIVE = 2'd2,
        WR       = 2'd3
    } sram_state_t;

    // Bank index width; a single bank still keeps one index bit.
    function automatic int bank_bits(input int cs_n);
        return (cs_n > 1) ? $clog2(cs_n) : 1;
    endfunction

endpackage

// File: rtl/sram_edge_sync.sv
// Registers one active-low strobe and flags its edges against the previous sample.
module sram_edge_sync (
    input  logic i_brd_clk,
    input  logic i_reset,
    input  logic strobe_n,
    output logic fall,
    output logic rise
);

    logic sample_reg;

    always_ff @(posedge i_brd_clk or posedge i_reset) begin
        if (i_reset) begin
            sample_reg <= 1'b1;
        end else begin
            sample_reg <= strobe_n;
        end
    end

    assign fall = sample_reg & ~strobe_n;
    assign rise = ~sample_reg & strobe_n;

endmodule

// File: rtl/sram_bank_model.sv
// Cycle-based bus-functional model of the external async SRAM: per-bank storage or
// counter pattern, configurable read latency, protocol error pulses and access counters.
module sram_bank_model
    import sram_bank_model_pkg::*;
#(
    parameter int                CS_N       = 4,
    parameter int                ADDR_W     = 21,
    parameter int                DATA_W     = 8,
    parameter int                DEPTH_LOG2 = 12,
    parameter int                READ_LAT   = 1,
    parameter int                MODE       = 1,
    parameter logic [DATA_W-1:0] INIT_VAL   = '0
) (
    input  logic              i_brd_clk,
    input  logic              i_reset,
    input  logic [CS_N-1:0]   i_sram_cs_n,
    input  logic              i_sram_read_n,
    input  logic              i_sram_write_n,
    input  logic [ADDR_W-1:0] i_sram_addr,
    inout  wire  [DATA_W-1:0] io_sram_data,
    output logic              o_err_multi_cs,
    output logic              o_err_rw,
    output logic [31:0]       o_rd_cnt,
    output logic [31:0]       o_wr_cnt
);

    localparam int BANK_W = bank_bits(CS_N);
    localparam int WORD_W = BANK_W + DEPTH_LOG2;

    sram_state_t state_reg, state_next;
    logic [2:0]  lat_reg, lat_next;
    logic        rd_done, wr_done;

    logic        rd_fall, rd_rise, wr_fall, wr_rise;
    int          cs_low;
    logic [BANK_W-1:0] bank;
    logic [WORD_W-1:0] word;
    logic        one_cs, multi_cs, no_cs;
    logic        both_low, both_high, strobe_low, start_ok;

    logic        rw_lock_reg, mc_lock_reg;
    logic        err_rw_reg, err_mc_reg;
    logic [31:0] rd_cnt_reg, wr_cnt_reg;
    logic [DATA_W-1:0] pat_reg;

    logic [DATA_W-1:0] mem_array [0:(2**WORD_W)-1];
    logic [DATA_W-1:0] rd_data_reg;
    logic [DATA_W-1:0] wr_data_reg;
    logic [WORD_W-1:0] wr_word_reg;
    logic              drive_en;
    logic [DATA_W-1:0] drive_data;

    sram_edge_sync u_rd_sync (
        .i_brd_clk (i_brd_clk),
        .i_reset   (i_reset),
        .strobe_n  (i_sram_read_n),
        .fall      (rd_fall),
        .rise      (rd_rise)
    );

    sram_edge_sync u_wr_sync (
        .i_brd_clk (i_brd_clk),
        .i_reset   (i_reset),
        .strobe_n  (i_sram_write_n),
        .fall      (wr_fall),
        .rise      (wr_rise)
    );

    always_comb begin
        cs_low = 0;
        bank   = '0;
        for (int i = 0; i < CS_N; i++) begin
            if (!i_sram_cs_n[i]) begin
                cs_low = cs_low + 1;
                bank   = BANK_W'(i);
            end
        end
    end

    // Upper address bits alias onto the implemented depth.
    generate
        if (ADDR_W > DEPTH_LOG2) begin : g_alias
            logic addr_hi_unused;
            assign addr_hi_unused = ^i_sram_addr[ADDR_W-1:DEPTH_LOG2];
        end
    endgenerate

    assign word       = {bank, i_sram_addr[DEPTH_LOG2-1:0]};
    assign one_cs     = (cs_low == 1);
    assign multi_cs   = (cs_low > 1);
    assign no_cs      = (cs_low == 0);
    assign both_low   = ~i_sram_read_n & ~i_sram_write_n;
    assign both_high  = i_sram_read_n & i_sram_write_n;
    assign strobe_low = ~both_high;
    assign start_ok   = one_cs & ~rw_lock_reg & ~mc_lock_reg;

    always_comb begin
        state_next = state_reg;
        lat_next   = lat_reg;
        rd_done    = 1'b0;
        wr_done    = 1'b0;
        case (state_reg)
            IDLE: begin
                lat_next = '0;
                if (start_ok && rd_fall && i_sram_write_n) begin
                    state_next = RD_WAIT;
                end else if (start_ok && wr_fall && i_sram_read_n) begin
                    state_next = WR;
                end
            end
            RD_WAIT: begin
                if (rd_rise) begin
                    state_next = IDLE;
                    rd_done    = 1'b1;
                end else if (lat_reg == 3'(READ_LAT)) begin
                    state_next = RD_DRIVE;
                end else begin
                    lat_next = lat_reg + 3'd1;
                end
            end
            RD_DRIVE: begin
                if (rd_rise) begin
                    state_next = IDLE;
                    rd_done    = 1'b1;
                end
            end
            WR: begin
                if (wr_rise) begin
                    state_next = IDLE;
                    wr_done    = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        // Protocol violations kill the access outright; losing chip select aborts it.
        if (both_low || multi_cs) begin
            state_next = IDLE;
            rd_done    = 1'b0;
            wr_done    = 1'b0;
        end else if (no_cs && !rd_done && !wr_done) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge i_brd_clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg   <= IDLE;
            lat_reg     <= '0;
            rd_cnt_reg  <= '0;
            wr_cnt_reg  <= '0;
            pat_reg     <= '0;
            err_rw_reg  <= 1'b0;
            err_mc_reg  <= 1'b0;
            rw_lock_reg <= 1'b0;
            mc_lock_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            lat_reg     <= lat_next;
            if (rd_done) begin
                rd_cnt_reg <= rd_cnt_reg + 32'd1;
                if (MODE == MODE_PATTERN) begin
                    pat_reg <= pat_reg + 1'b1;
                end
            end
            if (wr_done) begin
                wr_cnt_reg <= wr_cnt_reg + 32'd1;
            end
            err_rw_reg  <= both_low & ~rw_lock_reg;
            err_mc_reg  <= multi_cs & strobe_low & ~mc_lock_reg;
            // Locks hold until both strobes are back high, giving one pulse per access.
            rw_lock_reg <= both_low | (rw_lock_reg & ~both_high);
            mc_lock_reg <= (multi_cs & strobe_low) | (mc_lock_reg & ~both_high);
        end
    end

    // Array holds data ^ INIT_VAL so zeroed power-up content reads back as INIT_VAL.
    always_ff @(posedge i_brd_clk) begin
        if (wr_done && MODE == MODE_RAM) begin
            mem_array[wr_word_reg] <= wr_data_reg ^ INIT_VAL;
        end
        rd_data_reg <= mem_array[word];
        if (!i_sram_write_n) begin
            wr_word_reg <= word;
            wr_data_reg <= io_sram_data;
        end
    end

    assign drive_en     = (state_reg == RD_DRIVE);
    assign drive_data   = (MODE == MODE_RAM) ? (rd_data_reg ^ INIT_VAL) : pat_reg;
    assign io_sram_data = drive_en ? drive_data : 'z;

    assign o_err_multi_cs = err_mc_reg;
    assign o_err_rw       = err_rw_reg;
    assign o_rd_cnt       = rd_cnt_reg;
    assign o_wr_cnt       = wr_cnt_reg;

endmodule

// File: tb/tb_sram_bank_model.sv
// Bench for sram_bank_model: a RAM-mode and a pattern-mode instance share the control
// strobes; a plain array model and access counts give every expected value.
module tb_sram_bank_model;
    import sram_bank_model_pkg::*;

    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  cs_n;
    logic        rd_n, wr_n;
    logic [20:0] addr;
    logic [7:0]  tb_data;
    logic        tb_drv;

    // Pull-downs make an undriven bus read as 8'h00.
    tri0 [7:0]   bus_ram;
    tri0 [7:0]   bus_pat;
    assign bus_ram = tb_drv ? tb_data : 8'bz;

    logic        ram_err_mc, ram_err_rw, pat_err_mc, pat_err_rw;
    logic [31:0] ram_rd_cnt, ram_wr_cnt, pat_rd_cnt, pat_wr_cnt;

    int          vectors = 0;
    int          miscompares = 0;

    logic [7:0]  model_mem [0:16383];
    logic [31:0] model_rd, model_wr;

    sram_bank_model #(.READ_LAT(LAT), .MODE(MODE_RAM)) dut (
        .i_brd_clk      (clk),
        .i_reset        (rst),
        .i_sram_cs_n    (cs_n),
        .i_sram_read_n  (rd_n),
        .i_sram_write_n (wr_n),
        .i_sram_addr    (addr),
        .io_sram_data   (bus_ram),
        .o_err_multi_cs (ram_err_mc),
        .o_err_rw       (ram_err_rw),
        .o_rd_cnt       (ram_rd_cnt),
        .o_wr_cnt       (ram_wr_cnt)
    );

    sram_bank_model #(.READ_LAT(LAT), .MODE(MODE_PATTERN)) dut_pat (
        .i_brd_clk      (clk),
        .i_reset        (rst),
        .i_sram_cs_n    (cs_n),
        .i_sram_read_n  (rd_n),
        .i_sram_write_n (wr_n),
        .i_sram_addr    (addr),
        .io_sram_data   (bus_pat),
        .o_err_multi_cs (pat_err_mc),
        .o_err_rw       (pat_err_rw),
        .o_rd_cnt       (pat_rd_cnt),
        .o_wr_cnt       (pat_wr_cnt)
    );

    always #(CLK_PERIOD_BRD_PS / 2) clk = ~clk;

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic do_write(input int bank, input logic [20:0] a, input logic [7:0] d);
        @(negedge clk);
        cs_n = ~(4'b0001 << bank); addr = a; tb_data = d; tb_drv = 1'b1; wr_n = 1'b0;
        @(negedge clk);
        wr_n = 1'b1;
        @(negedge clk);
        tb_drv = 1'b0; cs_n = 4'hF;
        model_mem[bank * 4096 + int'(a[11:0])] = d;
        model_wr = model_wr + 1;
        $display("write bank=%0d addr=%h data=%h", bank, a, d);
    endtask

    // pre: OR of both buses during the latency window; post: RAM bus after the rise.
    task automatic do_read(input int bank, input logic [20:0] a, output logic [7:0] pre,
                           output logic [7:0] d_ram, output logic [7:0] d_pat,
                           output logic [7:0] post);
        @(negedge clk);
        cs_n = ~(4'b0001 << bank); addr = a; rd_n = 1'b0;
        pre = 8'h00;
        for (int i = 0; i <= LAT; i++) begin
            @(negedge clk);
            pre = pre | bus_ram | bus_pat;
        end
        @(negedge clk);
        d_ram = bus_ram; d_pat = bus_pat;
        rd_n = 1'b1;
        @(negedge clk);
        post = bus_ram;
        cs_n = 4'hF;
        model_rd = model_rd + 1;
        $display("read  bank=%0d addr=%h ram=%h pat=%h", bank, a, d_ram, d_pat);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_rd = 0; model_wr = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors += 6;
        if (ram_rd_cnt !== 32'd0) begin miscompares++; $display("FAIL reset_rd_cnt: got %0d expected 0", ram_rd_cnt); end
        if (ram_wr_cnt !== 32'd0) begin miscompares++; $display("FAIL reset_wr_cnt: got %0d expected 0", ram_wr_cnt); end
        if (ram_err_mc !== 1'b0) begin miscompares++; $display("FAIL reset_err_mc: got %b expected 0", ram_err_mc); end
        if (ram_err_rw !== 1'b0) begin miscompares++; $display("FAIL reset_err_rw: got %b expected 0", ram_err_rw); end
        if (bus_ram !== 8'h00) begin miscompares++; $display("FAIL reset_bus: got %h expected 00", bus_ram); end
        if (pat_rd_cnt !== 32'd0) begin miscompares++; $display("FAIL reset_pat_rd_cnt: got %0d expected 0", pat_rd_cnt); end
        $display("reset checked");
    endtask

    task automatic test_write_read();
        logic [7:0] pre, d_ram, d_pat, post;
        do_write(0, 21'h010, 8'hA5);
        do_read(0, 21'h010, pre, d_ram, d_pat, post);
        vectors += 5;
        if (pre !== 8'h00) begin miscompares++; $display("FAIL wr_rd_latency_z: got %h expected 00", pre); end
        if (d_ram !== model_mem[16]) begin miscompares++; $display("FAIL wr_rd_data: got %h expected %h", d_ram, model_mem[16]); end
        if (post !== 8'h00) begin miscompares++; $display("FAIL wr_rd_release: got %h expected 00", post); end
        if (ram_wr_cnt !== model_wr) begin miscompares++; $display("FAIL wr_rd_wr_cnt: got %0d expected %0d", ram_wr_cnt, model_wr); end
        if (ram_rd_cnt !== model_rd) begin miscompares++; $display("FAIL wr_rd_rd_cnt: got %0d expected %0d", ram_rd_cnt, model_rd); end
    endtask

    task automatic test_bank_isolation();
        logic [7:0] pre, d_ram, d_pat, post;
        do_write(1, 21'h003, 8'h11);
        do_read(2, 21'h003, pre, d_ram, d_pat, post);
        vectors++;
        if (d_ram !== model_mem[2 * 4096 + 3]) begin miscompares++; $display("FAIL bank_iso_cs2: got %h expected %h", d_ram, model_mem[2 * 4096 + 3]); end
        do_read(1, 21'h003, pre, d_ram, d_pat, post);
        vectors++;
        if (d_ram !== 8'h11) begin miscompares++; $display("FAIL bank_iso_cs1: got %h expected 11", d_ram); end
    endtask

    task automatic test_alias();
        logic [7:0] pre, d_ram, d_pat, post;
        do_write(0, 21'h1003, 8'h5C);
        do_read(0, 21'h0003, pre, d_ram, d_pat, post);
        vectors++;
        if (d_ram !== 8'h5C) begin miscompares++; $display("FAIL alias: got %h expected 5C", d_ram); end
    endtask

    task automatic test_random();
        logic [7:0]  pre, d_ram, d_pat, post, exp_pat;
        logic [20:0] a;
        int          bank;
        for (int n = 0; n < 40; n++) begin
            bank = int'($urandom_range(0, 3));
            a    = 21'($urandom_range(0, (1 << 21) - 1));
            if ($urandom_range(0, 1) == 0) begin
                do_write(bank, a, 8'($urandom));
            end else begin
                exp_pat = model_rd[7:0];
                do_read(bank, a, pre, d_ram, d_pat, post);
                vectors += 3;
                if (d_ram !== model_mem[bank * 4096 + int'(a[11:0])]) begin
                    miscompares++;
                    $display("FAIL rand_ram_data: got %h expected %h", d_ram, model_mem[bank * 4096 + int'(a[11:0])]);
                end
                if (d_pat !== exp_pat) begin miscompares++; $display("FAIL rand_pat_data: got %h expected %h", d_pat, exp_pat); end
                if (pre !== 8'h00) begin miscompares++; $display("FAIL rand_latency_z: got %h expected 00", pre); end
            end
        end
        vectors += 3;
        if (ram_rd_cnt !== model_rd) begin miscompares++; $display("FAIL rand_rd_cnt: got %0d expected %0d", ram_rd_cnt, model_rd); end
        if (ram_wr_cnt !== model_wr) begin miscompares++; $display("FAIL rand_wr_cnt: got %0d expected %0d", ram_wr_cnt, model_wr); end
        if (pat_wr_cnt !== model_wr) begin miscompares++; $display("FAIL rand_pat_wr_cnt: got %0d expected %0d", pat_wr_cnt, model_wr); end
    endtask

    task automatic test_multi_cs();
        logic [7:0] seen;
        do_write(0, 21'h010, 8'hA5);
        do_write(1, 21'h010, 8'h3C);
        @(negedge clk);
        cs_n = 4'b1100; addr = 21'h010; rd_n = 1'b0;
        @(negedge clk);
        vectors += 2;
        if (ram_err_mc !== 1'b1) begin miscompares++; $display("FAIL multi_cs_pulse: got %b expected 1", ram_err_mc); end
        if (bus_ram !== 8'h00) begin miscompares++; $display("FAIL multi_cs_bus: got %h expected 00", bus_ram); end
        seen = 8'h00;
        @(negedge clk);
        vectors++;
        if (ram_err_mc !== 1'b0) begin miscompares++; $display("FAIL multi_cs_single: got %b expected 0", ram_err_mc); end
        repeat (LAT + 2) begin
            @(negedge clk);
            seen = seen | bus_ram;
        end
        rd_n = 1'b1;
        @(negedge clk);
        cs_n = 4'hF;
        @(negedge clk);
        vectors += 3;
        if (seen !== 8'h00) begin miscompares++; $display("FAIL multi_cs_no_drive: got %h expected 00", seen); end
        if (ram_rd_cnt !== model_rd) begin miscompares++; $display("FAIL multi_cs_rd_cnt: got %0d expected %0d", ram_rd_cnt, model_rd); end
        if (ram_err_rw !== 1'b0) begin miscompares++; $display("FAIL multi_cs_err_rw: got %b expected 0", ram_err_rw); end
        $display("multi cs access cs_n=1100 done");
    endtask

    task automatic test_rw_conflict();
        logic [7:0] pre, d_ram, d_pat, post;
        @(negedge clk);
        cs_n = 4'b1110; addr = 21'h010; rd_n = 1'b0;
        repeat (LAT + 2) @(negedge clk);
        vectors++;
        if (bus_ram !== 8'hA5) begin miscompares++; $display("FAIL rw_pre_drive: got %h expected A5", bus_ram); end
        wr_n = 1'b0;
        @(negedge clk);
        vectors += 2;
        if (ram_err_rw !== 1'b1) begin miscompares++; $display("FAIL rw_pulse: got %b expected 1", ram_err_rw); end
        if (bus_ram !== 8'h00) begin miscompares++; $display("FAIL rw_bus_z: got %h expected 00", bus_ram); end
        @(negedge clk);
        vectors++;
        if (ram_err_rw !== 1'b0) begin miscompares++; $display("FAIL rw_single: got %b expected 0", ram_err_rw); end
        rd_n = 1'b1; wr_n = 1'b1;
        @(negedge clk);
        cs_n = 4'hF;
        $display("read/write conflict done");
        do_read(0, 21'h010, pre, d_ram, d_pat, post);
        vectors++;
        if (d_ram !== 8'hA5) begin miscompares++; $display("FAIL rw_mem_kept: got %h expected A5", d_ram); end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] pre, d_ram, d_pat, post;
        do_write(0, 21'h010, 8'hA5);
        @(negedge clk);
        cs_n = 4'b1110; addr = 21'h010; rd_n = 1'b0;
        repeat (LAT + 2) @(negedge clk);
        vectors++;
        if (bus_ram !== 8'hA5) begin miscompares++; $display("FAIL rst_pre_drive: got %h expected A5", bus_ram); end
        #(CLK_PERIOD_BRD_PS / 4);
        rst = 1'b1;
        #1;
        vectors += 3;
        if (bus_ram !== 8'h00) begin miscompares++; $display("FAIL rst_async_z: got %h expected 00", bus_ram); end
        if (ram_rd_cnt !== 32'd0) begin miscompares++; $display("FAIL rst_rd_cnt: got %0d expected 0", ram_rd_cnt); end
        if (ram_wr_cnt !== 32'd0) begin miscompares++; $display("FAIL rst_wr_cnt: got %0d expected 0", ram_wr_cnt); end
        @(negedge clk);
        rd_n = 1'b1; cs_n = 4'hF; rst = 1'b0;
        model_rd = 0; model_wr = 0;
        $display("reset during read done");
        do_read(0, 21'h010, pre, d_ram, d_pat, post);
        vectors += 2;
        if (d_ram !== 8'hA5) begin miscompares++; $display("FAIL rst_mem_kept: got %h expected A5", d_ram); end
        if (ram_rd_cnt !== model_rd) begin miscompares++; $display("FAIL rst_rd_cnt_after: got %0d expected %0d", ram_rd_cnt, model_rd); end
    endtask

    task automatic test_pattern();
        logic [7:0] pre, d_ram, d_pat, post, exp_pat;
        apply_reset();
        for (int n = 0; n < 258; n++) begin
            exp_pat = 8'(n % 256);
            do_read(int'($urandom_range(0, 3)), 21'($urandom_range(0, 4095)), pre, d_ram, d_pat, post);
            vectors++;
            if (d_pat !== exp_pat) begin miscompares++; $display("FAIL pattern_data: got %h expected %h", d_pat, exp_pat); end
        end
        vectors++;
        if (pat_rd_cnt !== 32'd258) begin miscompares++; $display("FAIL pattern_rd_cnt: got %0d expected 258", pat_rd_cnt); end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) model_mem[i] = 8'h00;
        model_rd = 0; model_wr = 0;
        rst = 1'b1; cs_n = 4'hF; rd_n = 1'b1; wr_n = 1'b1;
        addr = '0; tb_data = '0; tb_drv = 1'b0;
        test_reset();
        test_write_read();
        test_bank_isolation();
        test_alias();
        test_random();
        test_multi_cs();
        test_rw_conflict();
        test_reset_mid_read();
        test_pattern();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
